perf_counter_multi: RTL and testbench
=====================================

PERF_COUNTER_MULTI -- requirements
Module: perf_counter_multi

Interface
REQ-001 SHALL have parameter NUM_SECTIONS, default 8, number of timing sections (legal 1..16).
REQ-002 SHALL have parameter CNT_W, default 64, time-counter width in bits (legal 33..64).
REQ-003 SHALL have parameter EVT_W, default 32, event-counter width in bits (legal 1..32).
REQ-004 SHALL have port clk, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port address, input, 6: word address; section s occupies words 4s..4s+3.
REQ-007 SHALL have port begintransfer, input, 1: first cycle of an Avalon transfer.
REQ-008 SHALL have port read, input, 1: read request.
REQ-009 SHALL have port write, input, 1: write request.
REQ-010 SHALL have port writedata, input, 32: write data.
REQ-011 SHALL have port hw_start, input, NUM_SECTIONS: per-section hardware start pulse.
REQ-012 SHALL have port hw_stop, input, NUM_SECTIONS: per-section hardware stop pulse.
REQ-013 SHALL have port readdata, output, 32: registered read data.

Function
REQ-014 SHALL define wr_stb = write & begintransfer and rd_stb = read & begintransfer; other cycles of a transfer have no effect.
REQ-015 SHALL decode per section: word 0 write = stop, word 1 write = go, word 3 write = status clear; words 2 and unmapped addresses ignore writes.
REQ-016 SHALL decode word 0 write to section 0 with writedata[0]=1 as global_reset, clearing every time counter, event counter, enable, overflow flag and shadow in one cycle.
REQ-017 SHALL set section s enable on go (software or hw_start[s]) and clear it on stop (software or hw_stop[s]); stop wins when both occur in one cycle; global_reset wins over all.
REQ-018 SHALL define global_enable = enable_0 | go_0; no section counts while global_enable is 0.
REQ-019 SHALL increment time counter s by 1 per clock while enable_s & global_enable; first increment occurs the cycle after the go.
REQ-020 SHALL increment event counter s by 1 on each go of section s while global_enable, counting go while already running.
REQ-021 SHALL wrap each counter modulo 2^width and set a sticky overflow flag (time: bit1, event: bit2) on the wrap cycle.
REQ-022 SHALL clear overflow flags by writing 1 to status bits 1/2 at word 3; a clear and a wrap in the same cycle leave the flag set.
REQ-023 SHALL return on reads: word 0 time[31:0], word 1 shadow_s, word 2 event count zero-extended, word 3 {29'b0, evt_ovf, time_ovf, enable_s}; unmapped words read 0.
REQ-024 SHALL capture time[CNT_W-1:32] zero-extended into shadow_s on rd_stb to word 0, so a lo-then-hi read pair is coherent while counting.
REQ-025 SHALL register readdata with exactly one cycle latency from the address-valid cycle, updated every cycle.
REQ-026 SHALL treat hw_start/hw_stop as synchronous single-cycle pulses; a held level acts as repeated pulses.

Reset
REQ-027 SHALL, on reset_n low, asynchronously clear all counters, enables, flags, shadows and readdata to 0.
REQ-028 SHALL resume from the cleared state on the first clk edge after reset_n deasserts; reset mid-measurement discards all counts.

Configuration
REQ-029 SHALL, with macro PERF_COUNTER_HW_TRIG_EN defined, honour hw_start/hw_stop per REQ-017.
REQ-030 SHALL, without PERF_COUNTER_HW_TRIG_EN, keep hw_start/hw_stop ports but ignore them entirely; only software go/stop act.

Verification
REQ-031 SHALL cover: write go sec0, wait 10 cycles, write stop -> word0 reads 10 (+/-1 per REQ-019), word2 reads 1.
REQ-032 SHALL cover: go sec0 and sec3, stop sec0 after 5 cycles, wait 5 -> sec3 time stops at 5 while sec0 stopped.
REQ-033 SHALL cover: CNT_W=34, preload via run to 0x3_FFFF_FFFF -> next count wraps to 0, status reads 0x3 (running+time_ovf); write 0x2 clears to 0x1.
REQ-034 SHALL cover: lo read at 0xFFFF_FFFF, counter advances before hi read -> hi returns pre-wrap value 0.
REQ-035 SHALL cover: with macro, hw_start[2] and hw_stop[2] same cycle -> sec2 stays stopped; without macro, hw_start[2] pulse -> sec2 status 0.
REQ-036 SHALL cover: word0 sec0 write 0x1 while three sections run -> all counters, flags read 0 next cycle; reset_n low mid-run -> readdata 0 immediately.

Source files
------------

// File: rtl/perf_counter_multi.sv
// Multi-section performance counter with an Avalon-MM slave: per-section time/event counters,
// sticky overflow flags and a coherent hi-word shadow. Define PERF_COUNTER_HW_TRIG_EN to honour hw_start/hw_stop.
module perf_counter_multi #(
  parameter int NUM_SECTIONS = 8,
  parameter int CNT_W        = 64,
  parameter int EVT_W        = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [5:0]              address,
  input  logic                    begintransfer,
  input  logic                    read,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic [NUM_SECTIONS-1:0] hw_start,
  input  logic [NUM_SECTIONS-1:0] hw_stop,
  output logic [31:0]             readdata
);

  localparam int HI_W = CNT_W - 32;

  logic                    wr_stb;
  logic                    rd_stb;
  logic [3:0]              sec_idx;
  logic [1:0]              word_idx;
  logic                    global_reset;
  logic                    global_enable;
  logic [NUM_SECTIONS-1:0] hw_go;
  logic [NUM_SECTIONS-1:0] hw_halt;
  logic [NUM_SECTIONS-1:0] go_vec;
  logic [NUM_SECTIONS-1:0] enable_vec;
  logic [31:0]             rd_next;

  // Read words for all 16 decodable sections; sections beyond NUM_SECTIONS read as zero.
  logic [31:0] word0_all [16];
  logic [31:0] word1_all [16];
  logic [31:0] word2_all [16];
  logic [31:0] word3_all [16];

  assign wr_stb       = write & begintransfer;
  assign rd_stb       = read & begintransfer;
  assign sec_idx      = address[5:2];
  assign word_idx     = address[1:0];
  assign global_reset = wr_stb & (address == 6'd0) & writedata[0];

`ifdef PERF_COUNTER_HW_TRIG_EN
  assign hw_go   = hw_start;
  assign hw_halt = hw_stop;
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:3];
`else
  assign hw_go   = '0;
  assign hw_halt = '0;
  logic unused_inputs;
  assign unused_inputs = ^{writedata[31:3], hw_start, hw_stop};
`endif

  // Section 0 gates every section, including its own go in the same cycle.
  assign global_enable = enable_vec[0] | go_vec[0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SECTIONS; gi++) begin : g_sec
      localparam logic [3:0] SEC = 4'(gi);

      logic             sel;
      logic             sw_go;
      logic             sw_stop;
      logic             sw_clr;
      logic             sw_lo_rd;
      logic             go;
      logic             stop;
      logic             time_inc;
      logic             evt_inc;
      logic             time_wrap;
      logic             evt_wrap;
      logic             enable_reg;
      logic             enable_next;
      logic [CNT_W-1:0] time_reg;
      logic [CNT_W-1:0] time_next;
      logic [EVT_W-1:0] evt_reg;
      logic [EVT_W-1:0] evt_next;
      logic             time_ovf_reg;
      logic             time_ovf_next;
      logic             evt_ovf_reg;
      logic             evt_ovf_next;
      logic [HI_W-1:0]  shadow_reg;
      logic [HI_W-1:0]  shadow_next;

      assign sel      = (sec_idx == SEC);
      assign sw_stop  = wr_stb & sel & (word_idx == 2'd0);
      assign sw_go    = wr_stb & sel & (word_idx == 2'd1);
      assign sw_clr   = wr_stb & sel & (word_idx == 2'd3);
      assign sw_lo_rd = rd_stb & sel & (word_idx == 2'd0);

      assign go   = sw_go | hw_go[gi];
      assign stop = sw_stop | hw_halt[gi];

      assign time_inc  = enable_reg & global_enable;
      assign evt_inc   = go & global_enable;
      assign time_wrap = time_inc & (&time_reg);
      assign evt_wrap  = evt_inc & (&evt_reg);

      assign go_vec[gi]     = go;
      assign enable_vec[gi] = enable_reg;

      always_comb begin
        enable_next   = enable_reg;
        time_next     = time_reg;
        evt_next      = evt_reg;
        time_ovf_next = time_ovf_reg;
        evt_ovf_next  = evt_ovf_reg;
        shadow_next   = shadow_reg;

        if (stop) begin
          enable_next = 1'b0;
        end else if (go) begin
          enable_next = 1'b1;
        end

        if (time_inc) begin
          time_next = time_reg + CNT_W'(1);
        end
        if (evt_inc) begin
          evt_next = evt_reg + EVT_W'(1);
        end

        // A wrap in the same cycle as a clear leaves the flag set.
        if (sw_clr && writedata[1]) begin
          time_ovf_next = 1'b0;
        end
        if (sw_clr && writedata[2]) begin
          evt_ovf_next = 1'b0;
        end
        if (time_wrap) begin
          time_ovf_next = 1'b1;
        end
        if (evt_wrap) begin
          evt_ovf_next = 1'b1;
        end

        // Latch the upper bits as the low word is read so the following hi read is coherent.
        if (sw_lo_rd) begin
          shadow_next = time_reg[CNT_W-1:32];
        end

        if (global_reset) begin
          enable_next   = 1'b0;
          time_next     = '0;
          evt_next      = '0;
          time_ovf_next = 1'b0;
          evt_ovf_next  = 1'b0;
          shadow_next   = '0;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          enable_reg   <= 1'b0;
          time_reg     <= '0;
          evt_reg      <= '0;
          time_ovf_reg <= 1'b0;
          evt_ovf_reg  <= 1'b0;
          shadow_reg   <= '0;
        end else begin
          enable_reg   <= enable_next;
          time_reg     <= time_next;
          evt_reg      <= evt_next;
          time_ovf_reg <= time_ovf_next;
          evt_ovf_reg  <= evt_ovf_next;
          shadow_reg   <= shadow_next;
        end
      end

      assign word0_all[gi] = time_reg[31:0];
      assign word1_all[gi] = 32'(shadow_reg);
      assign word2_all[gi] = 32'(evt_reg);
      assign word3_all[gi] = {29'b0, evt_ovf_reg, time_ovf_reg, enable_reg};
    end

    for (gi = NUM_SECTIONS; gi < 16; gi++) begin : g_pad
      assign word0_all[gi] = 32'd0;
      assign word1_all[gi] = 32'd0;
      assign word2_all[gi] = 32'd0;
      assign word3_all[gi] = 32'd0;
    end
  endgenerate

  always_comb begin
    rd_next = 32'd0;
    case (word_idx)
      2'd0:    rd_next = word0_all[sec_idx];
      2'd1:    rd_next = word1_all[sec_idx];
      2'd2:    rd_next = word2_all[sec_idx];
      default: rd_next = word3_all[sec_idx];
    endcase
  end

  // Refreshed every cycle from the current address, independent of read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'd0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_perf_counter_multi.sv
// Directed, table-driven bench for perf_counter_multi (8 sections, 34-bit time, 4-bit event counters).
// Hardware-trigger checks follow PERF_COUNTER_HW_TRIG_EN.
module tb_perf_counter_multi;

  localparam int NS = 8;
  localparam int CW = 34;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [5:0]    address = '0;
  logic          begintransfer = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [NS-1:0] hw_start = '0;
  logic [NS-1:0] hw_stop = '0;
  logic [31:0]   readdata;

  int total = 0;
  int bad = 0;

  perf_counter_multi #(
    .NUM_SECTIONS(NS),
    .CNT_W(CW),
    .EVT_W(EW)
  ) u_dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .begintransfer(begintransfer),
    .read(read),
    .write(write),
    .writedata(writedata),
    .hw_start(hw_start),
    .hw_stop(hw_stop),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    write = 1'b1;
    begintransfer = 1'b1;
    @(posedge clk);
    #1;
    write = 1'b0;
    begintransfer = 1'b0;
    $display("wr   addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    read = 1'b1;
    begintransfer = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
    begintransfer = 1'b0;
    check(name, readdata, exp);
  endtask

  task automatic hw_pulse(input logic [NS-1:0] s, input logic [NS-1:0] p);
    hw_start = s;
    hw_stop = p;
    @(posedge clk);
    #1;
    hw_start = '0;
    hw_stop = '0;
    $display("hw   start=0x%02h stop=0x%02h", s, p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // {is_wr, addr, writedata, expected readdata}
    vecs[0]  = '{1'b0, 6'h00, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 6'h03, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 6'h01, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 6'h00, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, 6'h00, 32'h0,        32'h1};
    vecs[5]  = '{1'b0, 6'h02, 32'h0,        32'h1};
    vecs[6]  = '{1'b0, 6'h03, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 6'h02, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 6'h02, 32'h0,        32'h1};
    vecs[9]  = '{1'b1, 6'h0D, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 6'h0F, 32'h0,        32'h1};
    vecs[11] = '{1'b0, 6'h0E, 32'h0,        32'h0};
    vecs[12] = '{1'b0, 6'h0C, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 6'h0C, 32'h0,        32'h0};
    vecs[14] = '{1'b0, 6'h0F, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 6'h04, 32'h1,        32'h0};
    vecs[16] = '{1'b0, 6'h00, 32'h0,        32'h1};
    vecs[17] = '{1'b1, 6'h21, 32'h0,        32'h0};
    vecs[18] = '{1'b0, 6'h20, 32'h0,        32'h0};
    vecs[19] = '{1'b0, 6'h23, 32'h0,        32'h0};

    // Power-on reset
    idle(2);
    check("reset readdata", readdata, 32'h0);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table: one go/stop pair on sec0 gives time=1, event=1; sec3 go while globally disabled neither counts.
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) begin
        wr(vecs[i].addr, vecs[i].data);
      end else begin
        rd_chk($sformatf("vec%0d addr=0x%02h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
      end
    end

    // readdata follows the address even without a read strobe
    address = 6'h02;
    idle(1);
    check("no-strobe readdata", readdata, 32'h1);

    // Go sec0, 10 idle cycles, stop: the stop cycle still counts, so 11.
    wr(6'h00, 32'h1);
    wr(6'h01, 32'h0);
    idle(10);
    wr(6'h00, 32'h0);
    rd_chk("basic time", 6'h00, 32'd11);
    rd_chk("basic hi", 6'h01, 32'd0);
    rd_chk("basic events", 6'h02, 32'd1);
    rd_chk("basic status", 6'h03, 32'd0);

    // Sec0 and sec3 run; sec3 freezes once sec0 stops.
    wr(6'h00, 32'h1);
    wr(6'h01, 32'h0);
    wr(6'h0D, 32'h0);
    idle(4);
    wr(6'h00, 32'h0);
    idle(5);
    rd_chk("sec3 time frozen", 6'h0C, 32'd5);
    rd_chk("sec0 time", 6'h00, 32'd6);
    rd_chk("sec3 still enabled", 6'h0F, 32'h1);
    rd_chk("sec3 events", 6'h0E, 32'd1);
    wr(6'h0C, 32'h0);

    // Event counter wrap at 4 bits, counting go while running
    wr(6'h00, 32'h1);
    repeat (15) wr(6'h01, 32'h0);
    rd_chk("events 15", 6'h02, 32'd15);
    rd_chk("status pre evt wrap", 6'h03, 32'h1);
    wr(6'h01, 32'h0);
    rd_chk("events wrapped", 6'h02, 32'd0);
    rd_chk("status evt_ovf", 6'h03, 32'h5);
    wr(6'h03, 32'h4);
    rd_chk("status evt cleared", 6'h03, 32'h1);
    wr(6'h00, 32'h0);

    // Coherent lo/hi across a carry into bit 32
    wr(6'h00, 32'h1);
    force u_dut.g_sec[0].time_reg = 34'h0_FFFF_FFFE;
    idle(1);
    release u_dut.g_sec[0].time_reg;
    wr(6'h01, 32'h0);
    idle(1);
    rd_chk("lo at carry", 6'h00, 32'hFFFF_FFFF);
    rd_chk("hi pre-carry", 6'h01, 32'h0);
    rd_chk("lo after carry", 6'h00, 32'h1);
    rd_chk("hi after carry", 6'h01, 32'h1);
    wr(6'h00, 32'h0);

    // Time wrap at 34 bits, overflow flag and its clear
    wr(6'h00, 32'h1);
    force u_dut.g_sec[0].time_reg = 34'h3_FFFF_FFFE;
    idle(1);
    release u_dut.g_sec[0].time_reg;
    wr(6'h01, 32'h0);
    idle(1);
    rd_chk("status pre wrap", 6'h03, 32'h1);
    rd_chk("time wrapped", 6'h00, 32'h0);
    rd_chk("status time_ovf", 6'h03, 32'h3);
    wr(6'h03, 32'h2);
    rd_chk("status ovf cleared", 6'h03, 32'h1);
    wr(6'h00, 32'h0);

    // Clear and wrap in the same cycle keep the flag
    force u_dut.g_sec[0].time_reg = 34'h3_FFFF_FFFE;
    idle(1);
    release u_dut.g_sec[0].time_reg;
    wr(6'h01, 32'h0);
    idle(1);
    wr(6'h03, 32'h2);
    rd_chk("clear+wrap keeps ovf", 6'h03, 32'h3);
    wr(6'h00, 32'h0);

    // Hardware triggers on sec2 with sec0 running
    wr(6'h00, 32'h1);
    wr(6'h01, 32'h0);
`ifdef PERF_COUNTER_HW_TRIG_EN
    hw_pulse(8'h04, 8'h04);
    rd_chk("hw start+stop", 6'h0B, 32'h0);
    hw_pulse(8'h04, 8'h00);
    rd_chk("hw start", 6'h0B, 32'h1);
    hw_pulse(8'h00, 8'h04);
    rd_chk("hw stop", 6'h0B, 32'h0);
`else
    hw_pulse(8'h04, 8'h00);
    rd_chk("hw start ignored", 6'h0B, 32'h0);
    rd_chk("hw start no event", 6'h0A, 32'h0);
`endif
    wr(6'h00, 32'h0);

    // Global reset while three sections run
    wr(6'h00, 32'h1);
    wr(6'h01, 32'h0);
    wr(6'h05, 32'h0);
    wr(6'h09, 32'h0);
    idle(3);
    rd_chk("sec1 events before greset", 6'h06, 32'h1);
    wr(6'h00, 32'h1);
    rd_chk("greset sec0 time", 6'h00, 32'h0);
    rd_chk("greset sec1 time", 6'h04, 32'h0);
    rd_chk("greset sec2 events", 6'h0A, 32'h0);
    rd_chk("greset sec1 status", 6'h07, 32'h0);
    rd_chk("greset sec0 status", 6'h03, 32'h0);

    // Asynchronous reset mid-run
    wr(6'h01, 32'h0);
    address = 6'h00;
    idle(3);
    check("live readdata", readdata, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    check("async reset readdata", readdata, 32'h0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd_chk("post reset time", 6'h00, 32'h0);
    rd_chk("post reset status", 6'h03, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
